// File: rtl/dmem_mmio_cache_pkg.sv
// Shared definitions for the data-memory stage: default widths, MMIO word
// addresses and the cache controller state encoding.
package dmem_pkg;
  localparam int ADDR_LEN_DEF  = 25;
  localparam int INDEX_LEN_DEF = 10;
  localparam int DATA_W_DEF    = 32;

  localparam logic [1:0] MMIO_UART_DATA = 2'd0;
  localparam logic [1:0] MMIO_UART_STAT = 2'd1;
  localparam logic [1:0] MMIO_HITS      = 2'd2;
  localparam logic [1:0] MMIO_MISSES    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/dmem_mmio_cache_if.sv
// Backing-memory port: request held stable until a one-cycle ack, read data
// valid alongside the ack.
interface dmem_mmio_cache_if import dmem_pkg::*; #(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_W   = DATA_W_DEF
) ();
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_mmio_cache_array.sv
// Direct-mapped one-word-per-line storage: combinational lookup, synchronous
// write, and all valid bits cleared in a single reset cycle.
module dmem_cache_array import dmem_pkg::*; #(
  parameter int INDEX_LEN = INDEX_LEN_DEF,
  parameter int TAG_W     = ADDR_LEN_DEF - INDEX_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_LEN-1:0] index,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 wr_en,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [DATA_W-1:0]    wr_data
);
  localparam int DEPTH = 1 << INDEX_LEN;

  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tags [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_data  = data[index];

  // Valid bits: wiped on reset, set by any line write
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (wr_en) valid[index] <= 1'b1;
  end

  // Tag and data storage carry no reset; valid alone qualifies them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[index] <= wr_tag;
      data[index] <= wr_data;
    end
  end
endmodule

// File: rtl/dmem_mmio_cache.sv
// Data-memory stage: word addresses 0..3 are MMIO (UART data/status and,
// with DMEM_STATS_EN defined, hit/miss counters at 2/3); everything else goes
// through a direct-mapped write-through, no-write-allocate cache.
module dmem_mmio_cache import dmem_pkg::*; #(
  parameter int ADDR_LEN  = ADDR_LEN_DEF,
  parameter int INDEX_LEN = INDEX_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                n_stall,
  input  logic [ADDR_LEN-1:0] daddr,
  input  logic                mre,
  input  logic                mwe,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   wb_memdata,
  output logic                busy,
  input  logic [7:0]          rx_data,
  input  logic                rx_empty,
  output logic                rx_rd_en,
  output logic [7:0]          tx_data,
  input  logic                tx_full,
  output logic                tx_wr_en,
  dmem_mmio_cache_if.master   mem
);
  localparam int TAG_W = ADDR_LEN - INDEX_LEN;

  state_t               state;
  logic [INDEX_LEN-1:0] index;
  logic [TAG_W-1:0]     tag;
  logic                 mmio;
  logic [1:0]           mmio_sel;
  logic                 line_valid;
  logic [TAG_W-1:0]     line_tag;
  logic [DATA_W-1:0]    line_data;
  logic                 hit;
  logic                 accept;
  logic                 fill_done;
  logic                 store_upd;
  logic                 arr_we;
  logic [DATA_W-1:0]    arr_wdata;
  logic [DATA_W-1:0]    mmio_rdata;

  assign index    = daddr[INDEX_LEN-1:0];
  assign tag      = daddr[ADDR_LEN-1:INDEX_LEN];
  assign mmio     = (daddr < ADDR_LEN'(4));
  assign mmio_sel = daddr[1:0];
  assign hit      = line_valid && (line_tag == tag);

  // Stall: cached misses and every cached store leave IDLE; RESP always accepts
  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:        busy = n_stall && !mmio && ((mre && !hit) || mwe);
      FILL, WRITE: busy = 1'b1;
      default:     busy = 1'b0;
    endcase
    if (rst) busy = 1'b0;
  end

  assign accept = n_stall && !busy && !rst;

  // A fill lands on ack; a store only refreshes a line it already owns
  assign fill_done = (state == FILL) && mem.mem_ack && !rst;
  assign store_upd = (state == RESP) && accept && mwe && !mmio && hit;
  assign arr_we    = fill_done || store_upd;
  assign arr_wdata = fill_done ? mem.mem_rdata : wdata;

  dmem_cache_array #(
    .INDEX_LEN (INDEX_LEN),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_we),
    .wr_tag   (tag),
    .wr_data  (arr_wdata)
  );

  assign rx_rd_en = accept && mre && mmio && (mmio_sel == MMIO_UART_DATA) && !rx_empty;
  assign tx_wr_en = accept && mwe && mmio && (mmio_sel == MMIO_UART_DATA) && !tx_full;
  assign tx_data  = wdata[7:0];

`ifdef DMEM_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;
  logic        resp_fill;
  logic        cached_acc;
  logic        miss_evt;
  logic        stat_clr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign cached_acc = accept && !mmio && (mre || mwe);
  assign miss_evt   = ((state == RESP) && resp_fill) || (mwe && !hit);
  assign stat_clr   = accept && mwe && mmio && (mmio_sel == MMIO_HITS);

  // Remember whether RESP was reached through a fill (always a miss)
  always_ff @(posedge clk) begin
    if (state == FILL) resp_fill <= 1'b1;
    else if (state == WRITE) resp_fill <= 1'b0;
  end

  // Saturating hit/miss counters, cleared by reset or an MMIO write to addr 2
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      hits   <= '0;
      misses <= '0;
    end else if (cached_acc) begin
      if (miss_evt) misses <= sat_inc(misses);
      else hits <= sat_inc(hits);
    end
  end
`endif

  // MMIO read mux
  always_comb begin
    mmio_rdata = '0;
    case (mmio_sel)
      MMIO_UART_DATA: if (!rx_empty) mmio_rdata = DATA_W'(rx_data);
      MMIO_UART_STAT: mmio_rdata = DATA_W'({~tx_full, ~rx_empty});
`ifdef DMEM_STATS_EN
      MMIO_HITS:      mmio_rdata = DATA_W'(hits);
      MMIO_MISSES:    mmio_rdata = DATA_W'(misses);
`endif
      default:        mmio_rdata = '0;
    endcase
  end

  // Load result register, written only in the accepting cycle
  always_ff @(posedge clk) begin
    if (rst) wb_memdata <= '0;
    else if (accept && mre) wb_memdata <= mmio ? mmio_rdata : line_data;
  end

  // Controller FSM with registered request/direction
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (busy) begin
          state       <= mwe ? WRITE : FILL;
          mem.mem_req <= 1'b1;
          mem.mem_we  <= mwe;
        end
        FILL, WRITE: if (mem.mem_ack) begin
          state       <= RESP;
          mem.mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request address/data captured when leaving IDLE, held until ack
  always_ff @(posedge clk) begin
    if (state == IDLE && busy) begin
      mem.mem_addr  <= daddr;
      mem.mem_wdata <= wdata;
    end
  end
endmodule

// File: tb/tb_dmem_mmio_cache.sv
// Bench for dmem_mmio_cache: MMIO vector table, scoreboarded cached accesses
// against a backing-memory/cache model, and hand-written stall/reset sequences.
module tb_dmem_mmio_cache;
  import dmem_pkg::*;
  localparam int AL = 25;
  localparam int IL = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, n_stall, mre, mwe, busy;
  logic [AL-1:0] daddr;
  logic [DW-1:0] wdata, wb_memdata;
  logic [7:0]    rx_data, tx_data;
  logic          rx_empty, rx_rd_en, tx_full, tx_wr_en;

  dmem_mmio_cache_if #(.ADDR_LEN(AL), .DATA_W(DW)) mem_bus ();

  dmem_mmio_cache #(.ADDR_LEN(AL), .INDEX_LEN(IL), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .n_stall    (n_stall),
    .daddr      (daddr),
    .mre        (mre),
    .mwe        (mwe),
    .wdata      (wdata),
    .wb_memdata (wb_memdata),
    .busy       (busy),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .rx_rd_en   (rx_rd_en),
    .tx_data    (tx_data),
    .tx_full    (tx_full),
    .tx_wr_en   (tx_wr_en),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    bit          load;
    logic [7:0]  wd;
    logic [7:0]  rxd;
    bit          rxe;
    bit          txf;
    bit          exp_rd;
    bit          exp_wr;
    logic [31:0] exp_data;
  } vec_t;

  int                checks = 0;
  int                passes = 0;
  logic [31:0]       exp_q[$];
  logic [31:0]       last_wb;
  logic [31:0]       bmem [int];
  bit                m_val [1024];
  logic [AL-IL-1:0]  m_tag [1024];
  int                exp_hits, exp_misses;
  vec_t              vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_val(input int a);
    if (bmem.exists(a)) return bmem[a];
    return 32'h5A5A_0000 ^ 32'(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic sb_pop(input string name);
    logic [31:0] e;
    e = exp_q.pop_front();
    last_wb = e;
    check({name, " wb_memdata"}, wb_memdata, e);
  endtask

  // Called at a negedge; returns at the negedge after the access is accepted.
  task automatic access(input string name, input bit is_load, input logic [AL-1:0] a,
                        input logic [31:0] d);
    int  idx;
    bit  mhit;
    bit  req_seen;
    int  req_cycles;
    int  n;
    idx        = int'(a[IL-1:0]);
    mhit       = m_val[idx] && (m_tag[idx] == a[AL-1:IL]);
    req_seen   = 1'b0;
    req_cycles = 0;
    n          = 0;
    if (is_load) exp_q.push_back(mem_val(int'(a)));
    daddr = a; mre = is_load; mwe = !is_load; wdata = d; n_stall = 1'b1;
    forever begin
      #1;
      if (!busy) break;
      if (mem_bus.mem_req) begin
        if (!req_seen) begin
          check({name, " mem_we"}, 32'(mem_bus.mem_we), 32'(!is_load));
          check({name, " mem_addr"}, 32'(mem_bus.mem_addr), 32'(a));
          if (!is_load) check({name, " mem_wdata"}, mem_bus.mem_wdata, d);
        end
        req_seen = 1'b1;
        req_cycles++;
        if (req_cycles == 2) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = is_load ? mem_val(int'(a)) : $urandom;
          if (!is_load) bmem[int'(a)] = d;
        end
      end
      @(negedge clk);
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = $urandom;
      n++;
      if (n > 20) begin
        check({name, " timeout busy"}, 32'(busy), 32'd0);
        break;
      end
    end
    check({name, " mem traffic"}, 32'(req_seen), 32'(!(is_load && mhit)));
    if (is_load) begin
      if (mhit) exp_hits++;
      else begin
        exp_misses++;
        m_val[idx] = 1'b1;
        m_tag[idx] = a[AL-1:IL];
      end
    end else begin
      if (mhit) exp_hits++;
      else exp_misses++;
    end
    @(negedge clk);
    mre = 1'b0; mwe = 1'b0;
    if (is_load) sb_pop(name);
  endtask

  // Called at a negedge; one-cycle MMIO access.
  task automatic mmio(input string name, input vec_t v);
    daddr = AL'(v.addr); mre = v.load; mwe = !v.load; wdata = {24'h0, v.wd};
    rx_data = v.rxd; rx_empty = v.rxe; tx_full = v.txf; n_stall = 1'b1;
    #1;
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " rx_rd_en"}, 32'(rx_rd_en), 32'(v.exp_rd));
    check({name, " tx_wr_en"}, 32'(tx_wr_en), 32'(v.exp_wr));
    if (v.exp_wr) check({name, " tx_data"}, 32'(tx_data), 32'(v.wd));
    if (v.load) exp_q.push_back(v.exp_data);
    @(negedge clk);
    mre = 1'b0; mwe = 1'b0;
    if (v.load) sb_pop(name);
  endtask

  initial begin
    vec_t sv;
    rst = 1'b1; n_stall = 1'b0; mre = 1'b0; mwe = 1'b0; daddr = '0; wdata = '0;
    rx_data = 8'h00; rx_empty = 1'b1; tx_full = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    model_reset();
    last_wb = '0;

    //                addr  ld  wd     rxd    rxe txf rd wr data
    vecs[0] = '{2'd0, 1'b1, 8'h00, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 32'h41};
    vecs[1] = '{2'd0, 1'b1, 8'h00, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{2'd0, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{2'd0, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{2'd1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2};
    vecs[5] = '{2'd1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1};
    vecs[6] = '{2'd2, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{2'd3, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{2'd1, 1'b0, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    repeat (3) @(negedge clk);
    check("reset wb_memdata", wb_memdata, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem_req", 32'(mem_bus.mem_req), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) mmio($sformatf("mmio[%0d]", i), vecs[i]);
    rx_empty = 1'b1; tx_full = 1'b0;

    bmem[32'h100] = 32'hDEADBEEF;
    access("ld 100 miss", 1'b1, AL'(32'h100), 32'h0);
    access("ld 100 hit", 1'b1, AL'(32'h100), 32'h0);
    access("st 100", 1'b0, AL'(32'h100), 32'hCAFEF00D);
    access("ld 100 after st", 1'b1, AL'(32'h100), 32'h0);
    access("st 200 uncached", 1'b0, AL'(32'h200), 32'h12345678);
    access("ld 200 no alloc", 1'b1, AL'(32'h200), 32'h0);
    access("ld 100 again", 1'b1, AL'(32'h100), 32'h0);
    access("ld 500 conflict", 1'b1, AL'(32'h500), 32'h0);
    access("ld 100 evicted", 1'b1, AL'(32'h100), 32'h0);

    // n_stall low in IDLE: nothing starts, nothing pops, result holds
    daddr = AL'(32'h700); mre = 1'b1; n_stall = 1'b0;
    #1 check("nstall busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("nstall mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("nstall wb hold", wb_memdata, last_wb);
    daddr = '0; rx_empty = 1'b0; rx_data = 8'h33;
    #1 check("nstall rx_rd_en", 32'(rx_rd_en), 32'd0);
    @(negedge clk);
    check("nstall mmio wb hold", wb_memdata, last_wb);
    mre = 1'b0; n_stall = 1'b1; rx_empty = 1'b1;

    // Reset in the middle of a fill, then a late ack
    daddr = AL'(32'h300); mre = 1'b1;
    #1 check("rstfill busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("rstfill mem_req up", 32'(mem_bus.mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstfill mem_req drop", 32'(mem_bus.mem_req), 32'd0);
    check("rstfill busy low", 32'(busy), 32'd0);
    rst = 1'b0; mre = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("late ack mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("late ack busy", 32'(busy), 32'd0);
    model_reset();
    last_wb = '0;
    access("ld 300 after rst", 1'b1, AL'(32'h300), 32'h0);
    access("ld 300 hit", 1'b1, AL'(32'h300), 32'h0);
    access("ld 300 hit2", 1'b1, AL'(32'h300), 32'h0);
    access("st 300 hit", 1'b0, AL'(32'h300), 32'h0BADF00D);
    access("ld 100 post rst", 1'b1, AL'(32'h100), 32'h0);

`ifdef DMEM_STATS_EN
    sv = '{2'd2, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'(exp_hits)};
    mmio("stats hits", sv);
    sv = '{2'd3, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'(exp_misses)};
    mmio("stats misses", sv);
    sv = '{2'd2, 1'b0, 8'hEE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    mmio("stats clear", sv);
    sv = '{2'd2, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    mmio("stats hits cleared", sv);
    sv = '{2'd3, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    mmio("stats misses cleared", sv);
`else
    sv = '{2'd2, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    mmio("nostats addr2", sv);
    sv = '{2'd3, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    mmio("nostats addr3", sv);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_cache.md
Name: dmem_mmio_cache

Overview:
Data-memory stage unit for the core. Decodes word addresses below 4 as MMIO: UART data, UART status and optional statistics. All other addresses go through a direct-mapped, write-through, no-write-allocate cache backed by an external memory port with a req/ack handshake. Replaces the fixed UART-at-0 / address-echo memory stage and adds a real stall output.

Parameters:
ADDR_LEN, 25, word-address width
INDEX_LEN, 10, cache index bits (2**INDEX_LEN one-word lines)
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
n_stall  in  1  pipeline advancing; requests considered only when 1
daddr  in  ADDR_LEN  word address
mre  in  1  load request
mwe  in  1  store request (mre&mwe never both 1)
wdata  in  DATA_W  store data
wb_memdata  out  DATA_W  registered load result
busy  out  1  unit stall; core holds daddr/mre/mwe/wdata stable while 1
rx_data  in  8  RX FIFO head
rx_empty  in  1  RX FIFO empty
rx_rd_en  out  1  RX FIFO pop
tx_data  out  8  TX FIFO write data (= wdata[7:0])
tx_full  in  1  TX FIFO full
tx_wr_en  out  1  TX FIFO push
mem_req  out  1  backing-memory request
mem_we  out  1  request is write
mem_addr  out  ADDR_LEN  request address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  one-cycle completion; mem_rdata valid with it
mem_rdata  in  DATA_W  read data

Behaviour:
- Reset: wb_memdata=0, busy=0, mem_req=0, FSM=IDLE, all valid bits cleared in one cycle; stats counters=0.
- Address split: index=daddr[INDEX_LEN-1:0], tag=daddr[ADDR_LEN-1:INDEX_LEN]. mmio = (daddr < 4). MMIO is never cached and never stalls.
- MMIO read, addr 0: wb_memdata <= {24'b0, rx_data}. rx_rd_en = n_stall & mre & ~rx_empty. If the FIFO is empty, the read returns 0 and nothing is popped.
- MMIO read, addr 1: wb_memdata <= {30'b0, ~tx_full, ~rx_empty}.
- MMIO read, addr 2/3: return 0 (see the optional feature).
- MMIO write, addr 0: tx_wr_en = n_stall & mwe & ~tx_full. A write while tx_full is dropped silently. Writes to addr 1–3 are ignored.
- Load latency: wb_memdata is written at the clock edge ending the accepting cycle, i.e. the cycle with n_stall=1 and busy=0. It holds otherwise.
- FSM states: IDLE, FILL, WRITE, RESP.
  - IDLE, cached load hit: accept; wb_memdata <= line data.
  - IDLE, load miss: busy=1 combinationally; go to FILL.
  - IDLE, cached store: busy=1 combinationally; go to WRITE. The cache line is not touched in IDLE.
  - FILL: mem_req=1, mem_we=0, mem_addr=daddr, busy=1. On mem_ack: line <= mem_rdata, tag written, valid set; go to RESP.
  - WRITE: mem_req=1, mem_we=1, mem_wdata=wdata, busy=1. On mem_ack: go to RESP.
  - RESP: busy=0, so the request is accepted this cycle. It executes as a hit without memory traffic: a load returns the line; a store updates the line only if tag matches and valid (no allocate). Then go to IDLE.
- mem_req and its address/data stay stable until mem_ack. An ack seen in IDLE/RESP is ignored.
- n_stall=0 in IDLE: no action, no FIFO pop/push, wb_memdata holds. n_stall does not abort FILL/WRITE.
- Reset mid-FILL/WRITE: immediate return to IDLE, mem_req drops next cycle, the partial line is discarded.

Optional Feature:
DMEM_STATS_EN
- Defined: 32-bit saturating hit and miss counters, incremented on each accepted cached access. A RESP following FILL counts as a miss; a store counts as a hit if the line matched. Readable at MMIO addr 2 (hits) and addr 3 (misses). An MMIO write of any value to addr 2 clears both counters.
- Undefined: addr 2/3 read 0, no counters are synthesised.

Decomposition:
- Package dmem_pkg: ADDR_LEN/DATA_W defaults, MMIO address constants (MMIO_UART_DATA=0, MMIO_UART_STAT=1, MMIO_HITS=2, MMIO_MISSES=3), FSM state enum.
- One sub-module, dmem_cache_array: tag/valid/data storage with combinational read, synchronous write and a valid-clear on rst.

Test Plan:
- Load 0x100 after reset: busy=1, FILL, mem_ack with mem_rdata=0xDEADBEEF; RESP accepted, wb_memdata=0xDEADBEEF next edge. Repeat load: no mem_req, same data one cycle later.
- Store 0xCAFEF00D to cached 0x100: WRITE with mem_we=1, mem_addr=0x100; after ack, load 0x100 hits and returns 0xCAFEF00D. Store to uncached 0x200, then load 0x200: a miss (no allocate).
- Conflict: load 0x100 then load 0x100+2**INDEX_LEN: second access misses, evicts; reload 0x100 misses again.
- UART: rx_empty=0, rx_data=0x41, load addr 0 → rx_rd_en one cycle, wb_memdata=0x41. With rx_empty=1: wb_memdata=0, no pop. Store 0x5A to addr 0 with tx_full=1 → tx_wr_en=0. Read addr 1 with tx_full=0, rx_empty=1 → 0x2.
- Assert rst mid-FILL before ack: mem_req low next cycle, busy=0, a late ack is ignored, the following load to the same address misses.
- With DMEM_STATS_EN: 3 hits and 2 misses → addr 2 reads 3, addr 3 reads 2; store to addr 2 → both read 0.
